// File: rtl/pwm_capture_pkg.sv
// Shared types and helpers for the pwm_capture block.
// Optional idle timeout is compiled in with PWM_CAPTURE_TIMEOUT_EN.
package pwm_capture_pkg;

  // Per-channel measurement state
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_MEASURE   = 2'd2
  } state_t;

  // Returns {rise, fall} from the synchronized level and its delayed copy
  function automatic logic [1:0] edge_detect(input logic s, input logic s_d);
    return {s & ~s_d, ~s & s_d};
  endfunction

endpackage

// File: rtl/pwm_capture_channel.sv
// One PWM measurement channel: synchronizer, registered edge detect,
// IDLE/WAIT_RISE/MEASURE FSM, saturating counter and hold registers.
// With PWM_CAPTURE_TIMEOUT_EN an idle counter re-arms a stalled channel.
module pwm_capture_channel
  import pwm_capture_pkg::*;
#(
  parameter int CNT_WIDTH      = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter bit REF_SOURCE     = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic                 i_pwm,
  input  logic [CNT_WIDTH-1:0] i_ref_offset,
  output logic                 o_ref_rise,
  output logic [CNT_WIDTH-1:0] o_period,
  output logic [CNT_WIDTH-1:0] o_width,
  output logic [CNT_WIDTH-1:0] o_offset,
  output logic                 o_valid,
  output logic                 o_overflow,
  output logic                 o_timeout
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   r_rise;
  logic                   r_fall;
  logic [1:0]             w_edges;

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_width_hold;
  logic [CNT_WIDTH-1:0]   r_offset_hold;
  logic [CNT_WIDTH-1:0]   r_period;
  logic [CNT_WIDTH-1:0]   r_width;
  logic [CNT_WIDTH-1:0]   r_offset;
  logic                   r_valid;
  logic                   r_overflow;

`ifdef PWM_CAPTURE_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  logic [IDLE_W-1:0]      r_idle;
  logic                   r_timeout;
`endif

  assign w_edges = edge_detect(r_sync[SYNC_STAGES-1], r_s_d);

  // Synchronize the pin, then register the detected edges
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
      r_s_d  <= r_sync[SYNC_STAGES-1];
      r_rise <= w_edges[1];
      r_fall <= w_edges[0];
    end
  end

  // Measurement FSM: count between rises, capture width on fall, publish on rise
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_width_hold  <= '0;
      r_offset_hold <= '0;
      r_period      <= '0;
      r_width       <= '0;
      r_offset      <= '0;
      r_valid       <= 1'b0;
      r_overflow    <= 1'b0;
`ifdef PWM_CAPTURE_TIMEOUT_EN
      r_idle        <= '0;
      r_timeout     <= 1'b0;
`endif
    end else if (!i_enable) begin
      // Results are kept for software; only live state and sticky flags clear
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
`ifdef PWM_CAPTURE_TIMEOUT_EN
      r_idle     <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: r_state <= ST_WAIT_RISE;
        ST_WAIT_RISE: begin
          if (r_rise) begin
            r_state       <= ST_MEASURE;
            r_cnt         <= CNT_WIDTH'(1);
            r_offset_hold <= i_ref_offset;
          end
        end
        ST_MEASURE: begin
          if (r_rise) begin
            r_period      <= r_cnt;
            r_width       <= r_width_hold;
            r_offset      <= r_offset_hold;
            r_valid       <= 1'b1;
            r_cnt         <= CNT_WIDTH'(1);
            r_offset_hold <= i_ref_offset;
          end else begin
            if (r_cnt == CNT_MAX) r_overflow <= 1'b1;
            else                  r_cnt      <= r_cnt + 1'b1;
            if (r_fall) r_width_hold <= r_cnt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
`ifdef PWM_CAPTURE_TIMEOUT_EN
      // A quiet input re-arms the channel; this overrides the FSM step above
      if (r_state == ST_IDLE || r_rise || r_fall) begin
        r_idle <= '0;
      end else if (r_idle == IDLE_LAST) begin
        r_idle    <= '0;
        r_state   <= ST_WAIT_RISE;
        r_timeout <= 1'b1;
      end else begin
        r_idle <= r_idle + 1'b1;
      end
`endif
    end
  end

  // Only the reference channel drives the shared rise line
  assign o_ref_rise = REF_SOURCE & r_rise;
  assign o_period   = r_period;
  assign o_width    = r_width;
  assign o_offset   = r_offset;
  assign o_valid    = r_valid;
  assign o_overflow = r_overflow;
`ifdef PWM_CAPTURE_TIMEOUT_EN
  assign o_timeout  = r_timeout;
`else
  // No idle counter in this build: flag is a constant 0
  assign o_timeout  = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: rtl/pwm_capture.sv
// Multi-channel PWM capture: period, high width and rise offset vs channel 0.
// Define PWM_CAPTURE_TIMEOUT_EN to enable per-channel idle timeout.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int N_CHANNELS     = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [N_CHANNELS-1:0]           pwm_in,
  output logic [N_CHANNELS*CNT_WIDTH-1:0] period,
  output logic [N_CHANNELS*CNT_WIDTH-1:0] width,
  output logic [N_CHANNELS*CNT_WIDTH-1:0] offset,
  output logic [N_CHANNELS-1:0]           meas_valid,
  output logic [31:0]                     nb_pulses,
  output logic [N_CHANNELS-1:0]           overflow,
  output logic [N_CHANNELS-1:0]           timeout
);

  logic [N_CHANNELS-1:0] w_ref_rise;
  logic                  w_rise0;
  logic [CNT_WIDTH-1:0]  w_ref_offset;
  logic [CNT_WIDTH-1:0]  r_ref_cnt;
  logic [31:0]           r_nb_pulses;

  assign w_rise0      = |w_ref_rise;
  // A channel rising together with channel 0 sees offset 0
  assign w_ref_offset = w_rise0 ? '0 : r_ref_cnt;

  // Cycles since the last channel-0 rise, saturating
  always_ff @(posedge clk) begin
    if (reset || !enable)        r_ref_cnt <= '0;
    else if (w_rise0)            r_ref_cnt <= CNT_WIDTH'(1);
    else if (r_ref_cnt != '1)    r_ref_cnt <= r_ref_cnt + 1'b1;
  end

  // Channel-0 rise counter since enable, free-wrapping
  always_ff @(posedge clk) begin
    if (reset || !enable) r_nb_pulses <= '0;
    else if (w_rise0)     r_nb_pulses <= r_nb_pulses + 32'd1;
  end

  assign nb_pulses = r_nb_pulses;

  generate
    for (genvar gi = 0; gi < N_CHANNELS; gi++) begin : g_ch
      pwm_capture_channel #(
        .CNT_WIDTH      (CNT_WIDTH),
        .SYNC_STAGES    (SYNC_STAGES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .REF_SOURCE     (gi == 0)
      ) u_ch (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (enable),
        .i_pwm        (pwm_in[gi]),
        .i_ref_offset (w_ref_offset),
        .o_ref_rise   (w_ref_rise[gi]),
        .o_period     (period[gi*CNT_WIDTH +: CNT_WIDTH]),
        .o_width      (width[gi*CNT_WIDTH +: CNT_WIDTH]),
        .o_offset     (offset[gi*CNT_WIDTH +: CNT_WIDTH]),
        .o_valid      (meas_valid[gi]),
        .o_overflow   (overflow[gi]),
        .o_timeout    (timeout[gi])
      );
    end
  endgenerate

endmodule
